pwm_audio_out: RTL and testbench

//  Downstream consumer of the sine generator's 8-bit offset-binary amp_out. Converts each sample to a

---
 rtl/pwm_audio_out.sv | 180 ++++++++++++++++++
 tb/tb_pwm_audio_out.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_out.sv
// rtl/pwm_audio_out.sv - sample-paced PWM audio output; macro PWM_COMPLEMENTARY_EN adds dead-time pwm_n_out
module pwm_audio_out #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int DEADTIME = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] sample_in,
  output logic             step_out,
  output logic             pwm_out,
`ifdef PWM_COMPLEMENTARY_EN
  output logic             pwm_n_out,
`endif
  output logic             busy_out
);

  // Last counter value of a period: 2^WIDTH-2, so a period is 2^WIDTH-1 ticks.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("pwm_audio_out: PRESCALE must be >= 1");
  end
  if (DEADTIME < 0) begin : g_bad_deadtime
    $error("pwm_audio_out: DEADTIME must be >= 0");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  cnt;
  logic [PW-1:0]     presc;
  logic [WIDTH-1:0]  duty;
  logic              step_q;
  logic              load;
  logic              step_nx;
  logic              tick;
  logic              boundary;
  logic              active;
  logic              pwm_raw;

  assign tick     = (presc == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);
  assign active   = (state != IDLE);
  assign pwm_raw  = active && (cnt < duty);
  assign busy_out = active;
  assign step_out = step_q;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, sample load and step request; a period is never cut short by en_in.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (en_in) begin
          state_nx = RUN;
          load     = 1'b1;
          step_nx  = 1'b1;
        end
      end
      RUN: begin
        if (boundary) begin
          if (en_in) begin
            load    = 1'b1;
            step_nx = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (!en_in) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (boundary) begin
          if (en_in) begin
            state_nx = RUN;
            load     = 1'b1;
            step_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (en_in) begin
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Prescaler and period counter; both parked at zero while idle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc <= '0;
      cnt   <= '0;
    end else if (!active) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Duty latch and one-clock step pulse, both updated only at period starts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      duty   <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step_nx;
      if (load) begin
        duty <= sample_in;
      end
    end
  end

`ifdef PWM_COMPLEMENTARY_EN
  localparam int            DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [DW-1:0] DT = DW'(DEADTIME);

  logic [DW-1:0] hi_run;
  logic [DW-1:0] lo_run;
  logic          pwm_q;
  logic          pwm_n_q;

  // Saturating run-length of each raw phase; an output only goes high once its phase is DEADTIME long.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hi_run  <= '0;
      lo_run  <= '0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      hi_run  <= pwm_raw ? ((hi_run == DT) ? hi_run : hi_run + 1'b1) : '0;
      lo_run  <= (active && !pwm_raw) ? ((lo_run == DT) ? lo_run : lo_run + 1'b1) : '0;
      pwm_q   <= pwm_raw && (hi_run >= DT);
      pwm_n_q <= active && !pwm_raw && (lo_run >= DT);
    end
  end

  assign pwm_out   = pwm_q && active;
  assign pwm_n_out = pwm_n_q && active;
`else
  logic pwm_q;

  // Registered raw comparison, one clock behind the counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_raw;
    end
  end

  assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb/tb_pwm_audio_out.sv - randomized self-checking bench for pwm_audio_out
module tb_pwm_audio_out;

  localparam int PER1 = 255;
  localparam int PER3 = 765;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en1;
  logic       en3;
  logic [7:0] sample;
  logic       step1, pwm1, busy1;
  logic       step3, pwm3, busy3;
  logic       use3;
  logic       o_step, o_pwm, o_busy;
  logic [7:0] cur_duty;
  int         checks = 0;
  int         errors = 0;

`ifdef PWM_COMPLEMENTARY_EN
  logic pwm_n1, pwm_n3, o_pwm_n;
  assign o_pwm_n = use3 ? pwm_n3 : pwm_n1;
`endif

  assign o_step = use3 ? step3 : step1;
  assign o_pwm  = use3 ? pwm3  : pwm1;
  assign o_busy = use3 ? busy3 : busy1;

  always #5 clk = ~clk;

  pwm_audio_out #(.WIDTH(8), .PRESCALE(1), .DEADTIME(4)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .en_in     (en1),
    .sample_in (sample),
    .step_out  (step1),
    .pwm_out   (pwm1),
`ifdef PWM_COMPLEMENTARY_EN
    .pwm_n_out (pwm_n1),
`endif
    .busy_out  (busy1)
  );

  pwm_audio_out #(.WIDTH(8), .PRESCALE(3), .DEADTIME(4)) dut3 (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .en_in     (en3),
    .sample_in (sample),
    .step_out  (step3),
    .pwm_out   (pwm3),
`ifdef PWM_COMPLEMENTARY_EN
    .pwm_n_out (pwm_n3),
`endif
    .busy_out  (busy3)
  );

  // Observe one PWM period: samples 1..per after a step; nxt is presented at chg_at after a decoy at 3.
  task automatic measure(input int per, input logic [7:0] nxt, input int chg_at,
                         input int off_at, input int on_at,
                         output int hi, output int hi_n, output int both,
                         output int step_at, output int nsteps, output int busy_lo);
    hi = 0; hi_n = 0; both = 0; step_at = 0; nsteps = 0; busy_lo = 0;
    for (int n = 1; n <= per; n++) begin
      if (n == 3) sample = ~nxt;
      if (n == chg_at) sample = nxt;
      if (n == off_at) begin
        if (use3) en3 = 1'b0; else en1 = 1'b0;
      end
      if (n == on_at) begin
        if (use3) en3 = 1'b1; else en1 = 1'b1;
      end
      @(negedge clk);
      if (o_pwm) hi++;
`ifdef PWM_COMPLEMENTARY_EN
      if (o_pwm_n) hi_n++;
      if (o_pwm && o_pwm_n) both++;
`endif
      if (o_step) begin
        nsteps++;
        step_at = n;
      end
      if (!o_busy && n < per) busy_lo++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en1 = 1'b0; en3 = 1'b0; sample = 8'h00; use3 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({step1, pwm1, busy1} !== 3'b000) begin errors++; $display("FAIL reset_dut1: got %b expected 000", {step1, pwm1, busy1}); end
    checks++; if ({step3, pwm3, busy3} !== 3'b000) begin errors++; $display("FAIL reset_dut3: got %b expected 000", {step3, pwm3, busy3}); end
`ifdef PWM_COMPLEMENTARY_EN
    checks++; if ({pwm_n1, pwm_n3} !== 2'b00) begin errors++; $display("FAIL reset_pwm_n: got %b expected 00", {pwm_n1, pwm_n3}); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({step1, busy1} !== 2'b00) begin errors++; $display("FAIL idle_no_step: got %b expected 00", {step1, busy1}); end
  endtask

  task automatic start_run(input string tag, input logic [7:0] s);
    sample = s;
    if (use3) en3 = 1'b1; else en1 = 1'b1;
    @(negedge clk);
    checks++; if (o_step !== 1'b1) begin errors++; $display("FAIL %s_first_step: got %b expected 1", tag, o_step); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", tag, o_busy); end
    cur_duty = s;
  endtask

  task automatic test_one_period(input string tag, input int per, input int presc,
                                 input logic [7:0] nxt, input int chg_at);
    int hi, hi_n, both, step_at, nsteps, busy_lo, exp_hi;
    exp_hi = int'(cur_duty) * presc;
    measure(per, nxt, chg_at, 0, 0, hi, hi_n, both, step_at, nsteps, busy_lo);
    checks++; if (hi != exp_hi) begin errors++; $display("FAIL %s_high: got %0d expected %0d (duty %0d)", tag, hi, exp_hi, cur_duty); end
    checks++; if (step_at != per || nsteps != 1) begin errors++; $display("FAIL %s_step: got at %0d count %0d expected at %0d count 1", tag, step_at, nsteps, per); end
    checks++; if (busy_lo != 0) begin errors++; $display("FAIL %s_busy: got %0d low cycles expected 0", tag, busy_lo); end
    cur_duty = nxt;
  endtask

  task automatic test_mid_scale;
    use3 = 1'b0;
    start_run("mid", 8'h80);
    test_one_period("mid_p1", PER1, 1, 8'h80, 10);
    test_one_period("mid_p2", PER1, 1, 8'h00, 40);
  endtask

  task automatic test_extremes;
    test_one_period("zero_in", PER1, 1, 8'hFF, 30);
    for (int i = 0; i < 3; i++) test_one_period("full", PER1, 1, 8'hFF, 30);
    test_one_period("full_last", PER1, 1, 8'h40, 30);
  endtask

  task automatic test_late_change;
    test_one_period("late_base", PER1, 1, 8'hC0, 11);
    test_one_period("late_new", PER1, 1, 8'h80, 60);
  endtask

  task automatic test_random_duty;
    for (int i = 0; i < 6; i++) begin
      test_one_period("rand", PER1, 1, 8'($urandom), int'($urandom_range(4, PER1 - 2)));
    end
  endtask

  task automatic test_drain;
    int hi, hi_n, both, step_at, nsteps, busy_lo, bad;
    measure(PER1, 8'h33, 20, 101, 201, hi, hi_n, both, step_at, nsteps, busy_lo);
    checks++; if (hi != int'(cur_duty)) begin errors++; $display("FAIL regain_high: got %0d expected %0d", hi, cur_duty); end
    checks++; if (step_at != PER1 || nsteps != 1) begin errors++; $display("FAIL regain_step: got at %0d count %0d expected at %0d count 1", step_at, nsteps, PER1); end
    checks++; if (busy_lo != 0) begin errors++; $display("FAIL regain_busy: got %0d low cycles expected 0", busy_lo); end
    cur_duty = 8'h33;
    measure(PER1, 8'h55, 20, 101, 0, hi, hi_n, both, step_at, nsteps, busy_lo);
    checks++; if (hi != int'(cur_duty)) begin errors++; $display("FAIL drain_high: got %0d expected %0d", hi, cur_duty); end
    checks++; if (nsteps != 0) begin errors++; $display("FAIL drain_step: got %0d steps expected 0", nsteps); end
    checks++; if (busy_lo != 0 || o_busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %0d early low, final %b expected 0, 0", busy_lo, o_busy); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_step || o_pwm || o_busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_async_reset;
    use3 = 1'b0;
    start_run("ar", 8'h80);
    repeat (50) @(negedge clk);
    checks++; if (pwm1 !== 1'b1) begin errors++; $display("FAIL ar_pre_pwm: got %b expected 1", pwm1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({step1, pwm1, busy1} !== 3'b000) begin errors++; $display("FAIL ar_async: got %b expected 000", {step1, pwm1, busy1}); end
    @(negedge clk);
    rst_n = 1'b1;
    sample = 8'h80;
    @(negedge clk);
    checks++; if (step1 !== 1'b1) begin errors++; $display("FAIL ar_release_step: got %b expected 1", step1); end
    cur_duty = 8'h80;
    test_one_period("ar_after", PER1, 1, 8'h80, 20);
    rst_n = 1'b0; en1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_prescale;
    use3 = 1'b1;
    start_run("psc", 8'h80);
    test_one_period("psc_mid", PER3, 3, 8'($urandom), 100);
    test_one_period("psc_rand", PER3, 3, 8'h80, 400);
    en3 = 1'b0;
    use3 = 1'b0;
  endtask

`ifdef PWM_COMPLEMENTARY_EN
  task automatic test_complementary;
    int hi, hi_n, both, step_at, nsteps, busy_lo, d;
    use3 = 1'b0;
    start_run("cmp", 8'h80);
    measure(PER1, 8'h02, 20, 0, 0, hi, hi_n, both, step_at, nsteps, busy_lo);
    checks++; if (hi != 124) begin errors++; $display("FAIL cmp_hi: got %0d expected 124", hi); end
    checks++; if (hi_n != 123) begin errors++; $display("FAIL cmp_hi_n: got %0d expected 123", hi_n); end
    checks++; if (both != 0) begin errors++; $display("FAIL cmp_overlap: got %0d expected 0", both); end
    d = int'($urandom_range(10, 240));
    measure(PER1, 8'(d), 20, 0, 0, hi, hi_n, both, step_at, nsteps, busy_lo);
    checks++; if (hi != 0) begin errors++; $display("FAIL cmp_short_phase: got %0d expected 0", hi); end
    checks++; if (hi_n != 249) begin errors++; $display("FAIL cmp_short_n: got %0d expected 249", hi_n); end
    measure(PER1, 8'h80, 20, 0, 0, hi, hi_n, both, step_at, nsteps, busy_lo);
    checks++; if (hi != d - 4 || hi_n != 251 - d) begin errors++; $display("FAIL cmp_rand: got %0d/%0d expected %0d/%0d", hi, hi_n, d - 4, 251 - d); end
    checks++; if (both != 0) begin errors++; $display("FAIL cmp_rand_overlap: got %0d expected 0", both); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PWM_COMPLEMENTARY_EN
    test_complementary();
`else
    test_mid_scale();
    test_extremes();
    test_late_change();
    test_random_duty();
    test_drain();
    test_async_reset();
    test_prescale();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
